cardinal_nic: RTL and testbench
===============================

Name:
cardinal_nic

Overview:
- Network interface controller: memory-mapped responder to one processor node's data-memory port (addr/d_in/d_out/memEn/memWrEn style) and endpoint of one mesh router local port.
- Holds one 64-bit output-channel buffer (processor→network) and one 64-bit input-channel buffer (network→processor), each with a full flag.
- Sits between a four_stage_processor instance and its router inside the CMP top level.

Parameters:
- DATA_W, 64, packet/data width; all data ports are [0:DATA_W-1].
- ADDR_W, 2, register-select address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  [0:1]  register select from processor
- d_in  input  [0:63]  write data from processor
- d_out  output  [0:63]  read data to processor (registered)
- nicEn  input  1  access strobe for this NIC
- nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn)
- net_so  output  1  send strobe to router local input
- net_ro  input  1  router local input ready
- net_do  output  [0:63]  packet to router (= output buffer)
- net_polarity  input  1  router's current external VC phase
- net_si  input  1  send strobe from router local output
- net_ri  output  1  NIC ready to accept packet
- net_di  input  [0:63]  packet from router

Behaviour:
- Register map: 00 input-buffer data (read; pops); 01 input status (read; bit 63 = in_full, bits 0..62 = 0); 10 output-buffer data (write only); 11 output status (read; bit 63 = out_full, bits 0..62 = 0).
- Reset (synchronous): in_buf = 0, out_buf = 0, in_full = 0, out_full = 0, d_out = 0. Combinational outputs therefore read net_ri = 1, net_so = 0, net_do = 0 from the first post-reset cycle. Reset overrides every simultaneous event.
- Read: on an edge with nicEn=1 and nicWrEn=0, d_out <= selected register. 1-cycle latency: data is valid the cycle after the strobe. On all other edges d_out <= 0. Read of address 10 returns 0.
- Pop: read of address 00 while in_full=1 clears in_full at the same edge; d_out receives in_buf. Read of 00 while empty returns in_buf contents (stale) and changes no state.
- Write: on an edge with nicEn=1, nicWrEn=1 and addr=10: if out_full=0 (pre-edge value), out_buf <= d_in and out_full <= 1; if out_full=1, the write is silently dropped. Writes to 00, 01 and 11 are ignored.
- Send (combinational): net_so = out_full & net_ro & (out_buf[0] == net_polarity). Packet bit 0 is the VC bit. net_do = out_buf at all times. At an edge with net_so=1, out_full <= 0; out_buf is unchanged.
- Simultaneous send and write to 10 in the same cycle: the write is dropped because it uses the pre-edge out_full. The buffer is free on the following cycle.
- Receive: net_ri = ~in_full (combinational). At an edge with net_si=1 and net_ri=1: in_buf <= net_di, in_full <= 1. net_si while net_ri=0 is a router protocol violation; the NIC ignores it and in_buf is unchanged.
- Pop and receive never coincide, because net_ri=0 whenever in_full=1.
- Both channels are independent. Each holds at most one packet; there is no other queuing.

Test Plan:
- Reset: assert reset 2 cycles with net_si=1 and nicEn=1 -> d_out=0, net_so=0, net_ri=1; a status read of 01 or 11 returns 0.
- Write/send: polarity=0, net_ro=1; write 10 with 0x0123_4567_89AB_CDEF (bit0=0) -> next cycle net_so=1, net_do=that value; the cycle after, net_so=0; status 11 reads 0.
- Polarity gating: write a packet with bit0=1, net_polarity=0 -> net_so stays 0 and status 11 reads bit63=1; toggle polarity to 1 -> net_so=1 for exactly one cycle.
- Full drop: net_ro=0; write A=0xAAAA…, then B=0xBBBB… -> net_do stays A; raise net_ro -> A sent, B never appears.
- Receive/pop: net_si=1 with net_di=0xDEAD_BEEF_0000_0001 -> next cycle net_ri=0, status 01 reads bit63=1. Read 00 -> d_out equals the packet one cycle later and net_ri returns to 1 in the same cycle.
- Mid-operation reset: out_full=1 and in_full=1, assert reset -> both flags cleared, net_so=0, net_ri=1, d_out=0.

Source files
------------

// File: rtl/cardinal_nic.sv
// Network interface between one processor data-memory port and a mesh router local port.
// One-packet output channel (processor -> network) and one-packet input channel (network -> processor).
module cardinal_nic #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:ADDR_W-1] addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di
);

    localparam logic [0:ADDR_W-1] A_IN_DATA  = ADDR_W'(0);
    localparam logic [0:ADDR_W-1] A_IN_STAT  = ADDR_W'(1);
    localparam logic [0:ADDR_W-1] A_OUT_DATA = ADDR_W'(2);
    localparam logic [0:ADDR_W-1] A_OUT_STAT = ADDR_W'(3);

    logic [0:DATA_W-1] r_in_buf;
    logic [0:DATA_W-1] r_out_buf;
    logic              r_in_full;
    logic              r_out_full;
    logic [0:DATA_W-1] r_d_out;

    logic              w_rd;
    logic              w_wr_out;
    logic              w_pop;
    logic              w_send;
    logic              w_recv;
    logic [0:DATA_W-1] w_in_stat;
    logic [0:DATA_W-1] w_out_stat;
    logic [0:DATA_W-1] w_rd_data;

    assign w_rd     = nicEn & ~nicWrEn;
    assign w_wr_out = nicEn & nicWrEn & (addr == A_OUT_DATA);
    assign w_pop    = w_rd & (addr == A_IN_DATA) & r_in_full;
    // Packet bit 0 carries the VC; only send when it matches the router's current phase.
    assign w_send   = r_out_full & net_ro & (r_out_buf[0] == net_polarity);
    assign w_recv   = net_si & ~r_in_full;

    // Status flag lands in bit 63 (the numeric LSB of a [0:63] vector).
    assign w_in_stat  = {{(DATA_W-1){1'b0}}, r_in_full};
    assign w_out_stat = {{(DATA_W-1){1'b0}}, r_out_full};

    always_comb begin
        w_rd_data = '0;
        case (addr)
            A_IN_DATA:  w_rd_data = r_in_buf;
            A_IN_STAT:  w_rd_data = w_in_stat;
            A_OUT_STAT: w_rd_data = w_out_stat;
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_buf   <= '0;
            r_out_buf  <= '0;
            r_in_full  <= 1'b0;
            r_out_full <= 1'b0;
            r_d_out    <= '0;
        end else begin
            r_d_out <= w_rd ? w_rd_data : '0;

            // Send needs a full buffer and the write needs an empty one, so they never both fire;
            // a write racing a send is dropped because it sees the pre-edge full flag.
            if (w_send) begin
                r_out_full <= 1'b0;
            end else if (w_wr_out && !r_out_full) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end

            // Receive only while empty, pop only while full: mutually exclusive.
            if (w_recv) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_pop) begin
                r_in_full <= 1'b0;
            end
        end
    end

    assign d_out  = r_d_out;
    assign net_so = w_send;
    assign net_do = r_out_buf;
    assign net_ri = ~r_in_full;

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: a queue-based channel model predicts every cycle's outputs,
// a separate monitor pops those predictions (and expected sent packets) and compares.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:63] dout;
        logic [0:63] ndo;
        logic        so;
        logic        ri;
    } exp_t;

    exp_t        exp_q[$];
    logic [0:63] pkt_q[$];

    // Reference model: each channel is a queue holding at most one packet.
    logic [0:63] m_outq[$];
    logic [0:63] m_inq[$];
    logic [0:63] m_out_last;
    logic [0:63] m_in_last;
    logic [0:63] m_dout;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [0:63] act, input logic [0:63] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_outq.delete();
        m_inq.delete();
        m_out_last = '0;
        m_in_last  = '0;
        m_dout     = '0;
    endtask

    // Apply one cycle of inputs, record what the DUT must show before the coming edge,
    // then advance the model across that edge.
    task automatic step(input logic rst, input logic en, input logic wr, input logic [0:1] a,
                        input logic [0:63] din, input logic ro, input logic pol,
                        input logic si, input logic [0:63] di);
        exp_t        e;
        logic        so;
        logic [0:63] rd;
        @(negedge clk);
        reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_ro = ro; net_polarity = pol; net_si = si; net_di = di;

        so     = (m_outq.size() == 1) && ro && (m_outq[0][0] == pol);
        e.dout = m_dout;
        e.ndo  = m_out_last;
        e.so   = so;
        e.ri   = (m_inq.size() == 0);
        exp_q.push_back(e);
        if (so) pkt_q.push_back(m_outq[0]);

        if (rst) begin
            model_reset();
        end else begin
            rd = '0;
            if (en && !wr) begin
                case (a)
                    2'd0: rd = (m_inq.size() == 1) ? m_inq[0] : m_in_last;
                    2'd1: rd = 64'(m_inq.size());
                    2'd3: rd = 64'(m_outq.size());
                    default: rd = '0;
                endcase
                if (a == 2'd0 && m_inq.size() == 1) void'(m_inq.pop_front());
            end
            m_dout = rd;
            if (so) begin
                void'(m_outq.pop_front());
            end else if (en && wr && a == 2'd2 && m_outq.size() == 0) begin
                m_outq.push_back(din);
                m_out_last = din;
            end
            if (si && e.ri) begin
                m_inq.push_back(di);
                m_in_last = di;
            end
        end
    endtask

    task automatic idle(input logic ro, input logic pol);
        step(0, 0, 0, 2'd0, '0, ro, pol, 0, '0);
    endtask

    task automatic rd_reg(input logic [0:1] a, input logic ro, input logic pol);
        step(0, 1, 0, a, '0, ro, pol, 0, '0);
    endtask

    task automatic wr_out(input logic [0:63] v, input logic ro, input logic pol);
        step(0, 1, 1, 2'd2, v, ro, pol, 0, '0);
    endtask

    // Monitor: samples between the driver's negedge update and the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic [0:63] p;
        #3;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("d_out",  d_out, e.dout);
            chk("net_do", net_do, e.ndo);
            chk("net_so", 64'(net_so), 64'(e.so));
            chk("net_ri", 64'(net_ri), 64'(e.ri));
            if (net_so === 1'b1) begin
                if (pkt_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sent_pkt: got unexpected packet %h expected none", net_do);
                end else begin
                    p = pkt_q.pop_front();
                    chk("sent_pkt", net_do, p);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b1; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b1; net_di = '1;
        model_reset();

        // Reset held with strobes active, then status reads of both channels.
        step(1, 1, 0, 2'd1, '0, 0, 0, 1, '1);
        step(1, 1, 0, 2'd3, '0, 0, 0, 1, '1);
        rd_reg(2'd1, 0, 0);
        rd_reg(2'd3, 0, 0);
        idle(0, 0);

        // Write and immediate send on matching polarity.
        wr_out(64'h0123_4567_89AB_CDEF, 1, 0);
        idle(1, 0);
        rd_reg(2'd3, 1, 0);
        idle(1, 0);

        // Polarity gating: VC bit 1 waits for polarity 1.
        wr_out(64'h8000_0000_0000_0055, 1, 0);
        idle(1, 0);
        rd_reg(2'd3, 1, 0);
        idle(1, 0);
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);

        // Full drop: second write while full never reaches the network.
        wr_out(64'hAAAA_AAAA_AAAA_AAAA, 0, 1);
        wr_out(64'hBBBB_BBBB_BBBB_BBBB, 0, 1);
        idle(0, 1);
        idle(1, 1);
        idle(1, 1);
        idle(1, 0);
        rd_reg(2'd2, 1, 0);
        idle(1, 0);

        // Send racing a write: the write is dropped.
        wr_out(64'h0000_0000_0000_0011, 0, 0);
        idle(0, 0);
        step(0, 1, 1, 2'd2, 64'h0000_0000_0000_0022, 1, 0, 0, '0);
        idle(1, 0);
        rd_reg(2'd3, 1, 0);
        idle(1, 0);

        // Receive, status, pop, then stale read of empty buffer.
        step(0, 0, 0, 2'd0, '0, 0, 0, 1, 64'hDEAD_BEEF_0000_0001);
        step(0, 0, 0, 2'd0, '0, 0, 0, 1, 64'h1111_2222_3333_4444);
        rd_reg(2'd1, 0, 0);
        rd_reg(2'd0, 0, 0);
        rd_reg(2'd0, 0, 0);
        rd_reg(2'd1, 0, 0);
        idle(0, 0);

        // Mid-operation reset with both channels full.
        wr_out(64'h7777_0000_0000_0001, 0, 0);
        step(0, 0, 0, 2'd0, '0, 0, 0, 1, 64'hCAFE_F00D_0000_0002);
        rd_reg(2'd1, 0, 0);
        step(1, 1, 0, 2'd3, '0, 1, 0, 1, '1);
        idle(1, 0);
        rd_reg(2'd3, 1, 0);
        idle(1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [0:63] din, di;
            din = {$urandom, $urandom};
            di  = {$urandom, $urandom};
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 2'($urandom_range(0, 3)), din, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 2) == 0), di);
        end
        idle(0, 0);

        @(negedge clk);
        #6;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("pkt_q_drained", 64'(pkt_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
